// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbitration slice.
package uart_pkg;
  localparam int UART_BYTE_W = 8;
  localparam int GRANT_ID_W  = 3;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester set searching upward
// from the slot after the last owner, wrapping modulo N.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]            req,
  input  logic [GRANT_ID_W-1:0]   last,
  output logic [N-1:0]            gnt,
  output logic                    any
);

  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found && req[(int'(last) + k) % N]) begin
        gnt[(int'(last) + k) % N] = 1'b1;
        found = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of one UART tx core among N byte
// streams; owner keeps the grant until last byte, burst cap or stall timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N         = 4,
  parameter int MAX_BURST = 16,
  parameter int IDLE_TMO  = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N-1:0]             req_valid,
  input  logic [UART_BYTE_W*N-1:0] req_data,
  input  logic [N-1:0]             req_last,
  output logic [N-1:0]             req_ready,
  output logic [UART_BYTE_W-1:0]   tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [GRANT_ID_W-1:0]    grant_id,
  output logic                     busy
);

  arb_state_e             state;
  logic [GRANT_ID_W-1:0]  last_grant;
  logic [7:0]             burst_cnt;
  logic [9:0]             tmo_cnt;

  logic [N-1:0]           pick;
  logic                   pick_any;
  logic [GRANT_ID_W-1:0]  pick_idx;
  logic                   own_valid, own_last, accept;
  logic [UART_BYTE_W-1:0] own_byte;
  logic                   burst_hit, tmo_hit, release_now;
  logic [7:0]             burst_next;

  rr_arbiter #(.N(N)) u_rr (
    .req  (req_valid),
    .last (last_grant),
    .gnt  (pick),
    .any  (pick_any)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N; i++)
      if (pick[i]) pick_idx = GRANT_ID_W'(i);
  end

  // Owner's stream is muxed out; a byte is taken only when the output reg is free or draining.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_byte  = '0;
    req_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_id == GRANT_ID_W'(i)) begin
        own_valid    = req_valid[i];
        own_last     = req_last[i];
        own_byte     = req_data[i*UART_BYTE_W +: UART_BYTE_W];
        req_ready[i] = (state == GRANT) && req_valid[i] && (!tx_valid || tx_ready);
      end
    end
  end

  assign accept      = |req_ready;
  assign burst_hit   = ({1'b0, burst_cnt} + 9'd1) >= 9'(MAX_BURST);
  assign tmo_hit     = ({1'b0, tmo_cnt} + 11'd1) >= 11'(IDLE_TMO);
  assign burst_next  = (burst_cnt >= 8'(MAX_BURST)) ? burst_cnt : burst_cnt + 8'd1;
  assign release_now = accept ? (own_last || burst_hit) : (!own_valid && tmo_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      grant_id   <= '0;
      last_grant <= GRANT_ID_W'(N-1);
      burst_cnt  <= '0;
      tmo_cnt    <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
    end else begin
      // Output byte survives a release and drains before the next owner's first byte.
      if (accept) begin
        tx_data  <= own_byte;
        tx_valid <= 1'b1;
      end else if (tx_valid && tx_ready) begin
        tx_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pick_any) begin
            state     <= GRANT;
            busy      <= 1'b1;
            grant_id  <= pick_idx;
            burst_cnt <= '0;
            tmo_cnt   <= '0;
          end
        end
        GRANT: begin
          if (accept) begin
            burst_cnt <= burst_next;
            tmo_cnt   <= '0;
          end else if (!own_valid) begin
            tmo_cnt <= tmo_cnt + 10'd1;
          end
          if (release_now) begin
            state      <= IDLE;
            busy       <= 1'b0;
            last_grant <= grant_id;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: per-requester byte queues drive the DUT; a grant/packet
// level model predicts owner, release points and the tx byte stream.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N   = 4;
  localparam int MB  = 16;
  localparam int TMO = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [8*N-1:0]  req_data;
  logic [7:0]      tx_data;
  logic            tx_valid, tx_ready, busy;
  logic [2:0]      grant_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N(N), .MAX_BURST(MB), .IDLE_TMO(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  // pending bytes per requester: {last, data}
  logic [8:0] pq[N][$];
  logic [7:0] txq[$];
  logic [7:0] tx_log[$];
  int         glog[$];
  int         blog[$];
  int         txr_pct = 100;
  int         gap_pct = 0;

  int         m_last = N-1, m_owner = 0, m_cnt = 0, m_idle = 0;
  bit         m_busy_exp = 1'b0, prev_busy = 1'b0;
  logic [N-1:0] vld_prev = '0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) pq[i].delete();
    txq.delete();
    m_last = N-1; m_cnt = 0; m_idle = 0;
    m_busy_exp = 1'b0; prev_busy = 1'b0; vld_prev = '0;
  endtask

  task automatic monitor();
    int nacc, acc;
    bit rel;
    logic [N-1:0] exp_rdy;
    logic [8:0] h;
    nacc = 0; acc = -1; rel = 1'b0;
    chk("busy", busy, m_busy_exp);
    if (busy && !prev_busy) begin
      m_owner = rr_pick(vld_prev, m_last);
      chk("grant_id", grant_id, m_owner);
      glog.push_back(m_owner);
      m_cnt = 0; m_idle = 0;
    end
    if (!busy && prev_busy) begin
      blog.push_back(m_cnt);
      m_last = m_owner;
    end
    chk("tx_valid", tx_valid, txq.size() != 0);
    if (tx_valid && tx_ready && txq.size() != 0) begin
      chk("tx_data", tx_data, txq[0]);
      tx_log.push_back(tx_data);
      void'(txq.pop_front());
    end
    exp_rdy = '0;
    if (busy && req_valid[m_owner] && (!tx_valid || tx_ready)) exp_rdy[m_owner] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    for (int i = 0; i < N; i++) if (req_ready[i]) begin nacc++; acc = i; end
    if (nacc == 1 && pq[acc].size() != 0) begin
      h = pq[acc].pop_front();
      txq.push_back(h[7:0]);
      m_cnt++; m_idle = 0;
      rel = h[8] || (m_cnt == MB);
    end else if (busy && !req_valid[m_owner]) begin
      m_idle++;
      rel = (m_idle == TMO);
    end
    m_busy_exp = busy ? !rel : (req_valid != '0);
    prev_busy  = busy;
    vld_prev   = req_valid;
  endtask

  task automatic drive();
    logic [8:0] h;
    for (int i = 0; i < N; i++) begin
      h = (pq[i].size() != 0) ? pq[i][0] : 9'h0;
      req_valid[i] = (pq[i].size() != 0) && ($urandom_range(99) >= gap_pct);
      req_data[i*8 +: 8] = h[7:0];
      req_last[i] = h[8];
    end
    tx_ready = ($urandom_range(99) < txr_pct);
  endtask

  initial begin
    req_valid = '0; req_data = '0; req_last = '0; tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) model_reset();
      else monitor();
      @(posedge clk); #1;
      drive();
    end
  end

  task automatic push(input int r, input int len, input bit last, input int base);
    for (int k = 0; k < len; k++)
      pq[r].push_back({(last && k == len-1), 8'(base + k)});
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    bit done;
    n = 0; done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk); n++;
      done = !busy && !tx_valid && txq.size() == 0;
      for (int i = 0; i < N; i++) if (pq[i].size() != 0) done = 1'b0;
    end
    chk(tag, done, 1);
  endtask

  task automatic wait_tx(input string tag, input int cnt, input int budget);
    int n;
    n = 0;
    while (tx_log.size() < cnt && n < budget) begin @(negedge clk); n++; end
    chk(tag, tx_log.size() >= cnt, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #2 rst = 1'b0;
  endtask

  task automatic clear_logs();
    tx_log.delete(); glog.delete(); blog.delete();
  endtask

  initial begin
    int n;
    logic [7:0] snap;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_busy", busy, 0);

    // 1: single 3-byte packet from requester 0
    clear_logs();
    push(0, 3, 1'b1, 'hA1);
    wait_idle("t1_done", 200);
    chk("t1_len", tx_log.size(), 3);
    for (int k = 0; k < 3 && k < tx_log.size(); k++) chk("t1_byte", tx_log[k], 'hA1 + k);
    chk("t1_grants", glog.size(), 1);
    if (glog.size() > 0) chk("t1_gid", glog[0], 0);

    // 2: simultaneous requests, round-robin order
    do_reset();
    clear_logs();
    push(0, 1, 1'b1, 'h10);
    push(2, 1, 1'b1, 'h20);
    wait_idle("t2a_done", 200);
    push(0, 1, 1'b1, 'h30);
    wait_idle("t2b_done", 200);
    for (int i = 0; i < N; i++) push(i, 1, 1'b1, 'h40 + i);
    wait_idle("t2c_done", 300);
    chk("t2_grants", glog.size(), 7);
    if (glog.size() == 7) begin
      chk("t2_g0", glog[0], 0); chk("t2_g1", glog[1], 2); chk("t2_g2", glog[2], 0);
      chk("t2_g3", glog[3], 1); chk("t2_g4", glog[4], 2);
      chk("t2_g5", glog[5], 3); chk("t2_g6", glog[6], 0);
    end

    // 3: burst cap with a waiting requester
    clear_logs();
    push(1, 40, 1'b0, 'h00);
    push(3, 2, 1'b1, 'hC0);
    wait_idle("t3_done", 600);
    chk("t3_grants", glog.size(), 4);
    if (glog.size() >= 3 && blog.size() >= 3) begin
      chk("t3_g0", glog[0], 1); chk("t3_b0", blog[0], MB);
      chk("t3_g1", glog[1], 3); chk("t3_b1", blog[1], 2);
      chk("t3_g2", glog[2], 1); chk("t3_b2", blog[2], MB);
    end
    chk("t3_bytes", tx_log.size(), 42);

    // 4: stall timeout, then a waiting requester takes over
    clear_logs();
    push(2, 2, 1'b0, 'hD0);
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(busy && grant_id == 2 && !req_valid[2] && pq[2].size() == 0) && n < 300);
    chk("t4_stalled", n < 300, 1);
    push(0, 1, 1'b1, 'hD8);
    n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    chk("t4_tmo_cycles", n, TMO);
    @(negedge clk);
    chk("t4_next_busy", busy, 1);
    chk("t4_next_gid", grant_id, 0);
    wait_idle("t4_done", 200);

    // 5: tx core stalls mid-packet
    clear_logs();
    push(3, 6, 1'b1, 'hE0);
    wait_tx("t5_start", 2, 200);
    txr_pct = 0;
    @(negedge clk);
    snap = tx_data;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("t5_hold_valid", tx_valid, 1);
      chk("t5_hold_data", tx_data, snap);
      chk("t5_hold_ready", req_ready, 0);
    end
    txr_pct = 100;
    wait_idle("t5_done", 200);
    chk("t5_len", tx_log.size(), 6);
    for (int k = 0; k < 6 && k < tx_log.size(); k++) chk("t5_byte", tx_log[k], 'hE0 + k);

    // 6: reset mid-packet
    clear_logs();
    push(1, 8, 1'b1, 'h50);
    wait_tx("t6_start", 3, 200);
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    chk("t6_tx_valid", tx_valid, 0);
    chk("t6_tx_data", tx_data, 0);
    chk("t6_req_ready", req_ready, 0);
    chk("t6_grant_id", grant_id, 0);
    chk("t6_busy", busy, 0);
    @(posedge clk); #2 rst = 1'b0;
    clear_logs();
    push(1, 1, 1'b1, 'h60);
    push(0, 1, 1'b1, 'h61);
    wait_idle("t6_done", 200);
    chk("t6_grants", glog.size(), 2);
    if (glog.size() == 2) begin chk("t6_g0", glog[0], 0); chk("t6_g1", glog[1], 1); end

    // randomized traffic, tx back-pressure and requester gaps
    txr_pct = 70;
    gap_pct = 10;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if (pq[i].size() < 4 && $urandom_range(15) == 0)
          push(i, int'($urandom_range(12, 1)), $urandom_range(7) != 0, int'($urandom_range(255)));
    end
    gap_pct = 0;
    txr_pct = 100;
    wait_idle("rand_drain", 4000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
